// File: rtl/int_ctrl_8051.sv
// 8051-style interrupt controller: IE/IP SFRs, two-level priority arbitration,
// in-service tracking and a single registered vector presented to the CPU.
module int_ctrl_8051 #(
  parameter int unsigned NSRC = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            set_IE,
  input  logic            set_IP,
  input  logic [7:0]      ram_rd_byte,
  input  logic [NSRC-1:0] src_req,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_req,
  output logic [7:0]      int_vector,
  output logic [NSRC-1:0] src_clr,
  output logic [7:0]      ie_out,
  output logic [7:0]      ip_out
);

  localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;
  // The serial source (and anything above it) is cleared by software only.
  localparam int unsigned HW_CLR_SRCS = 4;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state;
  logic              svc_hi;
  logic              svc_lo;
  logic [IDXW-1:0]   win_idx;
  logic              win_hi;

  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   elig_hi;
  logic [NSRC-1:0]   elig_lo;
  logic              sel_found;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_hi;
  logic              ack_ok;
  logic              svc_hi_n;
  logic              svc_lo_n;

  // Arbitration: high-priority eligible sources win, lowest index breaks ties.
  always_comb begin
    pending   = src_req & ie_out[NSRC-1:0] & {NSRC{ie_out[7]}};
    elig_hi   = pending & ip_out[NSRC-1:0] & {NSRC{~svc_hi}};
    elig_lo   = pending & ~ip_out[NSRC-1:0] & {NSRC{~svc_hi & ~svc_lo}};
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_hi    = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig_lo[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
        sel_hi    = 1'b0;
      end
    end
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig_hi[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
        sel_hi    = 1'b1;
      end
    end
  end

  // In-service update: RETI clears the existing level first, then an ack sets.
  always_comb begin
    ack_ok   = (state == PRESENT) && int_ack;
    svc_hi_n = svc_hi;
    svc_lo_n = svc_lo;
    if (reti) begin
      if (svc_hi) svc_hi_n = 1'b0;
      else        svc_lo_n = 1'b0;
    end
    if (ack_ok) begin
      if (win_hi) svc_hi_n = 1'b1;
      else        svc_lo_n = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ie_out     <= '0;
      ip_out     <= '0;
      svc_hi     <= 1'b0;
      svc_lo     <= 1'b0;
      win_idx    <= '0;
      win_hi     <= 1'b0;
      int_req    <= 1'b0;
      int_vector <= '0;
      src_clr    <= '0;
    end else begin
      if (set_IE) ie_out <= ram_rd_byte;
      if (set_IP) ip_out <= ram_rd_byte;
      svc_hi  <= svc_hi_n;
      svc_lo  <= svc_lo_n;
      src_clr <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            win_idx    <= sel_idx;
            win_hi     <= sel_hi;
            int_vector <= 8'({sel_idx, 3'b011});
            int_req    <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= IDLE;
            if (32'(win_idx) < HW_CLR_SRCS) src_clr <= NSRC'(1) << win_idx;
          end else if (!pending[win_idx]) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
